// File: rtl/m31_dot_product_engine.sv
// Streaming dot-product engine over the Mersenne field p = 2^31-1.
// LANES products are reduced per beat and folded into a chainable accumulator.

package m31_dot_product_engine_pkg;
  localparam logic [31:0] M31_P = 32'h7FFF_FFFF;

  // Reduce any 64-bit value mod 2^31-1 by folding the high bits onto the low bits.
  function automatic logic [30:0] m31_red(input logic [63:0] x);
    logic [33:0] s1;
    logic [31:0] s2;
    s1 = {3'b0, x[30:0]} + {1'b0, x[63:31]};
    s2 = {1'b0, s1[30:0]} + {29'b0, s1[33:31]};
    if (s2 >= M31_P) s2 = s2 - M31_P;
    return s2[30:0];
  endfunction
endpackage

module m31_mul_lane
  import m31_dot_product_engine_pkg::*;
(
  input  logic [30:0] a,
  input  logic [30:0] b,
  output logic [30:0] prod
);
  logic [30:0] a_c, b_c;
  logic [63:0] full;

  // 2^31-1 is congruent to zero; squash it so every product is of canonical operands
  assign a_c  = (a == 31'h7FFF_FFFF) ? 31'd0 : a;
  assign b_c  = (b == 31'h7FFF_FFFF) ? 31'd0 : b;
  assign full = {33'b0, a_c} * {33'b0, b_c};
  assign prod = m31_red(full);
endmodule

module m31_dot_product_engine
  import m31_dot_product_engine_pkg::*;
#(
  parameter int WORD_WIDTH  = 31,
  parameter int VECTOR_SIZE = 16,
  parameter int LANES       = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             chain,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [LANES-1:0][WORD_WIDTH-1:0] in_a,
  input  logic [LANES-1:0][WORD_WIDTH-1:0] in_b,
  output logic                             busy,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [WORD_WIDTH-1:0]            res_data
);
  localparam int BEATS = VECTOR_SIZE / LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (WORD_WIDTH != 31 || LANES < 1 || (VECTOR_SIZE % LANES) != 0) begin : g_param_err
    $error("m31_dot_product_engine: illegal parameterisation");
  end

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t                          state_q, state_d;
  logic [WORD_WIDTH-1:0]           acc;
  logic [CNT_W-1:0]                cnt;
  logic [LANES-1:0][WORD_WIDTH-1:0] lane_prod;
  logic [63:0]                     beat_sum;
  logic [WORD_WIDTH-1:0]           acc_next;
  logic                            beat, last;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    m31_mul_lane u_lane (
      .a    (in_a[i]),
      .b    (in_b[i]),
      .prod (lane_prod[i])
    );
  end

  // Each term is < 2^31, so 64 bits hold acc plus any realistic lane count
  always_comb begin
    beat_sum = {{(64-WORD_WIDTH){1'b0}}, acc};
    for (int i = 0; i < LANES; i++)
      beat_sum = beat_sum + {{(64-WORD_WIDTH){1'b0}}, lane_prod[i]};
    acc_next = m31_red(beat_sum);
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == DONE);
  assign res_data  = res_valid ? acc : '0;
  assign beat      = in_valid && in_ready;
  assign last      = (cnt == CNT_W'(BEATS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)        state_d = ACCUM;
      ACCUM:   if (beat && last) state_d = DONE;
      DONE:    if (res_ready)    state_d = IDLE;
      default:                   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && start) begin
        cnt <= '0;
        if (!chain) acc <= '0;
      end
      if (beat) begin
        acc <= acc_next;
        cnt <= last ? '0 : cnt + CNT_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_m31_dot_product_engine.sv
// Self-checking bench: vector table, hand-written corner sequences and random ops
// compared against a plain-arithmetic mod-p model.

module tb_m31_dot_product_engine;
  localparam int W = 31, N = 16, L = 4, B = N / L;
  localparam longint unsigned P = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset, start, chain, in_valid, res_ready;
  logic in_ready, busy, res_valid;
  logic [W-1:0] res_data;
  logic [L-1:0][W-1:0] in_a, in_b;

  m31_dot_product_engine #(.WORD_WIDTH(W), .VECTOR_SIZE(N), .LANES(L)) dut (
    .clk(clk), .reset(reset), .start(start), .chain(chain),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  always #5 clk = ~clk;

  int passed = 0, total = 0;
  longint unsigned acc_m;
  logic [L-1:0][W-1:0] op_a [B];
  logic [L-1:0][W-1:0] op_b [B];

  typedef struct {
    bit              ch;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    longint unsigned exp;
  } vec_t;
  vec_t tbl [7];

  task automatic chk(input string nm, input longint unsigned act, input longint unsigned exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  function automatic longint unsigned beat_dot(input logic [L-1:0][W-1:0] a,
                                               input logic [L-1:0][W-1:0] b);
    longint unsigned s = 0;
    for (int i = 0; i < L; i++) begin
      longint unsigned x = a[i], y = b[i];
      s = (s + ((x % P) * (y % P)) % P) % P;
    end
    return s;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_uniform(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < B; k++)
      for (int i = 0; i < L; i++) begin
        op_a[k][i] = a;
        op_b[k][i] = b;
      end
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(7, 0))
      0:       return 31'h7FFF_FFFF;
      1:       return 31'h7FFF_FFFE;
      2:       return 31'd0;
      default: return W'($urandom);
    endcase
  endfunction

  task automatic fill_random();
    for (int k = 0; k < B; k++)
      for (int i = 0; i < L; i++) begin
        op_a[k][i] = rnd_word();
        op_b[k][i] = rnd_word();
      end
  endtask

  // One full operation; gaps/stalls are random up to the given bounds.
  task automatic run_op(input bit ch, input int max_gap, input int rdy_delay,
                        input bit poke, output longint unsigned got);
    start = 1'b1; chain = ch;
    tick();
    start = 1'b0; chain = 1'b0;
    if (!ch) acc_m = 0;
    chk("in_ready_accum", in_ready, 1);
    for (int k = 0; k < B; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        start = poke;
        tick();
        start = 1'b0;
      end
      in_a = op_a[k]; in_b = op_b[k]; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      acc_m = (acc_m + beat_dot(op_a[k], op_b[k])) % P;
    end
    chk("res_valid_latency", res_valid, 1);
    chk("res_data", res_data, acc_m);
    got = res_data;
    for (int d = 0; d < rdy_delay; d++) begin
      start = poke;
      tick();
      start = 1'b0;
      chk("hold_valid", res_valid, 1);
      chk("hold_data", res_data, acc_m);
      chk("hold_in_ready", in_ready, 0);
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("idle_after_ack", {busy, in_ready, res_valid, res_data}, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    longint unsigned got;
    reset = 1'b1; start = 1'b0; chain = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
    in_a = '0; in_b = '0; acc_m = 0;

    tbl[0] = '{1'b0, 31'd1,          31'd1,          64'd16};
    tbl[1] = '{1'b0, 31'h7FFF_FFFE,  31'h7FFF_FFFE,  64'd16};
    tbl[2] = '{1'b0, 31'h4000_0000,  31'd4,          64'd32};
    tbl[3] = '{1'b0, 31'h7FFF_FFFF,  31'd5,          64'd0};
    tbl[4] = '{1'b0, 31'd1,          31'd1,          64'd16};
    tbl[5] = '{1'b1, 31'd1,          31'd1,          64'd32};
    tbl[6] = '{1'b0, 31'd1,          31'd1,          64'd16};

    tick(); tick();
    chk("reset_outputs", {busy, in_ready, res_valid, res_data}, 0);
    reset = 1'b0;
    tick();

    // After reset a chained op must start from zero
    fill_uniform(31'd1, 31'd1);
    run_op(1'b1, 0, 0, 1'b0, got);
    chk("chain_after_reset", got, 16);

    for (int t = 0; t < 7; t++) begin
      fill_uniform(tbl[t].a, tbl[t].b);
      run_op(tbl[t].ch, 0, 1, 1'b0, got);
      chk($sformatf("table_%0d", t), got, tbl[t].exp);
    end

    // Lane 2 holds 2^31-1 and contributes nothing: 3 lanes * 5 * 4 beats
    fill_uniform(31'd1, 31'd5);
    for (int k = 0; k < B; k++) op_a[k][2] = 31'h7FFF_FFFF;
    run_op(1'b0, 0, 0, 1'b0, got);
    chk("lane_p_zero", got, 60);

    // Gaps with stray start pulses, result held 5 cycles
    fill_uniform(31'd1, 31'd1);
    run_op(1'b0, 3, 5, 1'b1, got);
    chk("stall_result", got, 16);

    // Reset mid-accumulation
    fill_uniform(31'd1, 31'd1);
    start = 1'b1; chain = 1'b0;
    tick();
    start = 1'b0;
    in_a = op_a[0]; in_b = op_b[0]; in_valid = 1'b1;
    tick(); tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("mid_reset_outputs", {busy, in_ready, res_valid, res_data}, 0);
    reset = 1'b0;
    acc_m = 0;
    run_op(1'b1, 0, 0, 1'b0, got);
    chk("post_reset_chain", got, 16);

    for (int n = 0; n < 1000; n++) begin
      fill_random();
      run_op(1'($urandom_range(1, 0)), 2, $urandom_range(3, 0), 1'($urandom_range(1, 0)), got);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
